led_blink_rate_detector: RTL and testbench

//  Receive-side counterpart of the LED blink generator. Measures the half-period
//  of an external toggling signal and classifies it as 10/5/2/1 Hz or unknown.

---
 rtl/led_blink_rate_detector.sv | 132 +++++++++++++
 tb/tb_led_blink_rate_detector.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/led_blink_rate_detector.sv
// Measures the half-period of an asynchronous toggling input and classifies it
// as 10/5/2/1 Hz, unknown, or lost (no edge within the timeout window).
module led_blink_rate_detector #(
  parameter int unsigned g_HALF_10HZ = 1250000,
  parameter int unsigned g_HALF_5HZ  = 2500000,
  parameter int unsigned g_HALF_2HZ  = 6250000,
  parameter int unsigned g_HALF_1HZ  = 12500000,
  parameter int unsigned g_TOL_SHIFT = 4,
  parameter int unsigned g_TIMEOUT   = 25000000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Signal,
  output logic        o_Valid,
  output logic [2:0]  o_Rate,
  output logic [31:0] o_Half_Period,
  output logic        o_Timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } t_state;

  t_state      r_State;
  t_state      w_Next_State;
  logic        r_Sync1;
  logic        r_Sync2;
  logic        r_Sync3;
  logic [31:0] r_Count;
  logic [31:0] w_Count_Nxt;
  logic        w_Edge;
  logic        w_Expire;
  logic [32:0] w_Meas;
  logic        w_Valid_Nxt;
  logic [2:0]  w_Rate_Nxt;
  logic [31:0] w_Half_Nxt;
  logic        w_Timeout_Nxt;

  // Tolerance window test done in 33-bit signed math so M below the nominal
  // value cannot wrap.
  function automatic logic in_band(input logic [32:0] meas, input logic [31:0] half);
    logic signed [32:0] diff;
    logic signed [32:0] tol;
    diff = $signed(meas) - $signed({1'b0, half});
    if (diff < 33'sd0) diff = -diff;
    tol = $signed({1'b0, half >> g_TOL_SHIFT});
    return (diff <= tol);
  endfunction

  function automatic logic [2:0] classify(input logic [32:0] meas);
    if (in_band(meas, g_HALF_10HZ)) return 3'd4;
    if (in_band(meas, g_HALF_5HZ))  return 3'd3;
    if (in_band(meas, g_HALF_2HZ))  return 3'd2;
    if (in_band(meas, g_HALF_1HZ))  return 3'd1;
    return 3'd7;
  endfunction

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Sync1 <= 1'b0;
      r_Sync2 <= 1'b0;
      r_Sync3 <= 1'b0;
    end else begin
      r_Sync1 <= i_Signal;
      r_Sync2 <= r_Sync1;
      r_Sync3 <= r_Sync2;
    end
  end

  assign w_Edge   = r_Sync2 ^ r_Sync3;
  assign w_Expire = (r_Count == (g_TIMEOUT - 32'd1));
  assign w_Meas   = {1'b0, r_Count} + 33'd1;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State       <= IDLE;
      r_Count       <= 32'd0;
      o_Valid       <= 1'b0;
      o_Rate        <= 3'd0;
      o_Half_Period <= 32'd0;
      o_Timeout     <= 1'b0;
    end else begin
      r_State       <= w_Next_State;
      r_Count       <= w_Count_Nxt;
      o_Valid       <= w_Valid_Nxt;
      o_Rate        <= w_Rate_Nxt;
      o_Half_Period <= w_Half_Nxt;
      o_Timeout     <= w_Timeout_Nxt;
    end
  end

  always_comb begin
    w_Next_State = r_State;
    case (r_State)
      IDLE:    if (w_Edge) w_Next_State = MEASURE;
      MEASURE: if (!w_Edge && w_Expire) w_Next_State = LOST;
      LOST:    if (w_Edge) w_Next_State = MEASURE;
      default: w_Next_State = IDLE;
    endcase
  end

  // An edge on the expiry cycle takes priority, so a half-period of exactly
  // g_TIMEOUT is still measured.
  always_comb begin
    w_Count_Nxt   = 32'd0;
    w_Valid_Nxt   = 1'b0;
    w_Rate_Nxt    = o_Rate;
    w_Half_Nxt    = o_Half_Period;
    w_Timeout_Nxt = o_Timeout;
    case (r_State)
      MEASURE: begin
        if (w_Edge) begin
          w_Valid_Nxt = 1'b1;
          w_Half_Nxt  = w_Meas[31:0];
          w_Rate_Nxt  = classify(w_Meas);
        end else if (w_Expire) begin
          w_Timeout_Nxt = 1'b1;
          w_Rate_Nxt    = 3'd0;
        end else begin
          w_Count_Nxt = r_Count + 32'd1;
        end
      end
      LOST: begin
        if (w_Edge) w_Timeout_Nxt = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_blink_rate_detector.sv
// Bench for led_blink_rate_detector: table-driven half-period vectors with a
// scoreboard of expected measurements, plus hand-built latency/timeout/reset cases.
module tb_led_blink_rate_detector;
  localparam int TMO = 400;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig   = 1'b0;
  logic        o_Valid;
  logic [2:0]  o_Rate;
  logic [31:0] o_Half;
  logic        o_Timeout;

  led_blink_rate_detector #(
    .g_HALF_10HZ(20),
    .g_HALF_5HZ (40),
    .g_HALF_2HZ (100),
    .g_HALF_1HZ (200),
    .g_TOL_SHIFT(2),
    .g_TIMEOUT  (TMO)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Signal     (sig),
    .o_Valid      (o_Valid),
    .o_Rate       (o_Rate),
    .o_Half_Period(o_Half),
    .o_Timeout    (o_Timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int half; logic [2:0] rate; } vec_t;
  typedef struct { logic [2:0] rate; logic [31:0] half; } exp_t;

  exp_t q[$];
  int   n_vec   = 0;
  int   n_miss  = 0;
  int   n_valid = 0;
  int   lag     = 0;
  bit   armed   = 1'b0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every o_Valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_Valid) begin
      n_valid++;
      chk("valid_back_to_back", 32'(prev_valid), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("rate", 32'(o_Rate), 32'(e.rate));
        chk("half_period", o_Half, e.half);
      end
    end
    prev_valid <= rst_n & o_Valid;
  end

  // Toggle the input h clocks after the previous toggle; push the expected
  // measurement when the DUT is already timing a half-period.
  task automatic step(input int h, input logic [2:0] r);
    exp_t e;
    repeat (h - lag) @(negedge clk);
    lag = 0;
    sig = ~sig;
    if (armed && h <= TMO) begin
      e.rate = r;
      e.half = 32'(h);
      q.push_back(e);
    end
    armed = 1'b1;
  endtask

  initial begin
    vec_t tbl [17];
    int   nv;
    bit   saw;
    exp_t e;
    tbl[0]  = '{20,  3'd4}; tbl[1]  = '{15,  3'd4}; tbl[2]  = '{25,  3'd4};
    tbl[3]  = '{14,  3'd7}; tbl[4]  = '{26,  3'd7}; tbl[5]  = '{30,  3'd3};
    tbl[6]  = '{40,  3'd3}; tbl[7]  = '{50,  3'd3}; tbl[8]  = '{51,  3'd7};
    tbl[9]  = '{75,  3'd2}; tbl[10] = '{100, 3'd2}; tbl[11] = '{125, 3'd2};
    tbl[12] = '{126, 3'd7}; tbl[13] = '{150, 3'd1}; tbl[14] = '{200, 3'd1};
    tbl[15] = '{250, 3'd1}; tbl[16] = '{251, 3'd7};

    // Reset held while the input toggles
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clk);
      sig = ~sig;
      @(negedge clk);
      chk("reset_valid_timeout", {30'd0, o_Valid, o_Timeout}, 32'd0);
      chk("reset_rate", 32'(o_Rate), 32'd0);
      chk("reset_half", o_Half, 32'd0);
    end
    sig = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b0;

    step(20, 3'd4);
    repeat (4) @(negedge clk);
    lag = 4;
    chk("no_valid_first_edge", 32'(n_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(20, 3'd4);

    // Classification bins and tolerance bounds
    foreach (tbl[i]) begin
      step(tbl[i].half, tbl[i].rate);
      step(tbl[i].half, tbl[i].rate);
    end

    // Latency: pulse appears 3 negedges after the toggle, one cycle wide
    step(20, 3'd4);
    @(negedge clk); chk("lat_n1", 32'(o_Valid), 32'd0);
    @(negedge clk); chk("lat_n2", 32'(o_Valid), 32'd0);
    @(negedge clk); chk("lat_n3", 32'(o_Valid), 32'd1);
    @(negedge clk); chk("lat_n4", 32'(o_Valid), 32'd0);
    lag = 4;

    // Timeout and recovery
    step(20, 3'd4);
    repeat (402) @(negedge clk);
    chk("timeout_early", 32'(o_Timeout), 32'd0);
    @(negedge clk);
    chk("timeout_set", 32'(o_Timeout), 32'd1);
    chk("timeout_rate", 32'(o_Rate), 32'd0);
    chk("timeout_half_kept", o_Half, 32'd20);
    lag = 403;
    nv = n_valid;
    step(500, 3'd0);
    repeat (2) @(negedge clk);
    chk("timeout_held", 32'(o_Timeout), 32'd1);
    @(negedge clk);
    chk("timeout_clear", 32'(o_Timeout), 32'd0);
    @(negedge clk);
    chk("no_valid_after_timeout_edge", 32'(n_valid), 32'(nv));
    lag = 4;
    step(20, 3'd4);
    step(20, 3'd4);

    // Edge landing on the expiry cycle is measured, no timeout
    saw = 1'b0;
    repeat (TMO) begin
      @(negedge clk);
      saw |= o_Timeout;
    end
    sig = ~sig;
    e.rate = 3'd7;
    e.half = 32'(TMO);
    q.push_back(e);
    repeat (4) begin
      @(negedge clk);
      saw |= o_Timeout;
    end
    lag = 4;
    chk("edge_on_timeout_no_timeout", 32'(saw), 32'd0);
    step(20, 3'd4);

    // Asynchronous reset between clock edges
    step(20, 3'd4);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid_timeout", {30'd0, o_Valid, o_Timeout}, 32'd0);
    chk("async_rst_rate", 32'(o_Rate), 32'd0);
    chk("async_rst_half", o_Half, 32'd0);
    sig = 1'b0;
    armed = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = n_valid;
    step(20, 3'd4);
    repeat (5) @(negedge clk);
    chk("no_valid_first_edge_after_rst", 32'(n_valid), 32'(nv));
    lag = 5;
    step(20, 3'd4);
    repeat (6) @(negedge clk);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
